// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access-size encodings, MEM-stage FSM state
// and the request record latched while a multi-cycle access is in flight.
package mips_pkg;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {IDLE, BUSY} dmemState_t;

  typedef struct packed {
    logic             wr;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [1:0]       size;
    logic             sgn;
    logic [REG_W-1:0] rd;
    logic             rfwr;
  } memReq_t;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lsb[0];
      default:   return |lsb;
    endcase
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte-enables and data
// replication, load extraction with zero/sign extension, alignment check.
module dmem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]      addrLsb,
  input  logic [1:0]      size,
  input  logic            sgn,
  input  logic [XLEN-1:0] storeData,
  input  logic [XLEN-1:0] ramWord,
  output logic [3:0]      byteEn,
  output logic [XLEN-1:0] wrData,
  output logic [XLEN-1:0] loadData,
  output logic            misalign
);
  logic [7:0]  selByte;
  logic [15:0] selHalf;

  assign misalign = isMisaligned(size, addrLsb);
  assign selByte  = ramWord[{addrLsb, 3'b000} +: 8];
  assign selHalf  = ramWord[{addrLsb[1], 4'b0000} +: 16];

  always_comb begin
    byteEn   = 4'b1111;
    wrData   = storeData;
    loadData = ramWord;
    case (size)
      SIZE_BYTE: begin
        byteEn   = 4'b0001 << addrLsb;
        wrData   = {4{storeData[7:0]}};
        loadData = {{24{sgn & selByte[7]}}, selByte};
      end
      SIZE_HALF: begin
        byteEn   = addrLsb[1] ? 4'b1100 : 4'b0011;
        wrData   = {2{storeData[15:0]}};
        loadData = {{16{sgn & selHalf[15]}}, selHalf};
      end
      default: ;
    endcase
    // A misaligned access must leave every lane untouched.
    if (misalign) byteEn = 4'b0000;
  end
endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data-memory responder: word RAM with optional wait states,
// pipeline stall generation and registered MEM/WB outputs.
module mem_stage_dmem
  import mips_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_wr,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [REG_W-1:0] req_rd,
  input  logic             req_rfwr,
  input  logic [XLEN-1:0]  pass_data,
  output logic             stall_o,
  output logic [XLEN-1:0]  wb_data,
  output logic [REG_W-1:0] wb_rd,
  output logic             wb_rfwr,
  output logic             misalign_o
);
  localparam int  AW    = $clog2(DEPTH);
  localparam bit  MULTI = (WAIT_CYCLES != 0);

  dmemState_t      state, stateNxt;
  logic [3:0]      cnt;
  memReq_t         held, inReq, cur;
  logic [XLEN-1:0] ram [DEPTH];
  logic [AW-1:0]   idx;
  logic            accept, complete, ramWe;
  logic [3:0]      byteEn;
  logic [XLEN-1:0] wrData, loadData;
  logic            misalign;
  logic            unusedAddr;

  assign inReq = '{wr: req_wr, addr: req_addr, wdata: req_wdata, size: req_size,
                   sgn: req_signed, rd: req_rd, rfwr: req_rfwr};
  // While BUSY the EX/MEM inputs are ignored; only the latched copy counts.
  assign cur        = (state == BUSY) ? held : inReq;
  assign idx        = cur.addr[AW+1:2];
  assign unusedAddr = ^cur.addr[XLEN-1:AW+2];

  dmem_lane_align uAlign (
    .addrLsb   (cur.addr[1:0]),
    .size      (cur.size),
    .sgn       (cur.sgn),
    .storeData (cur.wdata),
    .ramWord   (ram[idx]),
    .byteEn    (byteEn),
    .wrData    (wrData),
    .loadData  (loadData),
    .misalign  (misalign)
  );

  always_comb begin
    stateNxt = state;
    accept   = 1'b0;
    complete = 1'b0;
    if (!MULTI) begin
      complete = req_valid;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          accept   = 1'b1;
          stateNxt = BUSY;
        end
        BUSY: if (cnt == 4'd1) begin
          complete = 1'b1;
          stateNxt = IDLE;
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  assign stall_o = !rst && (accept || (state == BUSY && cnt > 4'd1));
  assign ramWe   = complete && cur.wr && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      held  <= '0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        held <= inReq;
        cnt  <= 4'(WAIT_CYCLES);
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // RAM has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (ramWe)
      for (int n = 0; n < 4; n++)
        if (byteEn[n]) ram[idx][8*n +: 8] <= wrData[8*n +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data    <= '0;
      wb_rd      <= '0;
      wb_rfwr    <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      if (complete) begin
        wb_rd      <= cur.rd;
        misalign_o <= misalign;
        if (misalign || cur.wr) begin
          wb_data <= '0;
          wb_rfwr <= 1'b0;
        end else begin
          wb_data <= loadData;
          wb_rfwr <= cur.rfwr;
        end
      end else if (accept || state == BUSY) begin
        wb_rfwr <= 1'b0;
      end else if (!req_valid) begin
        wb_data <= pass_data;
        wb_rd   <= req_rd;
        wb_rfwr <= req_rfwr;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Bench for mem_stage_dmem: three instances (0, 2 and 3 wait states), a directed
// vector table, hand sequences for reset abort, and randomized accesses vs a model.
module tb_mem_stage_dmem;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid [3];
  logic        reqWr    [3];
  logic [31:0] reqAddr  [3];
  logic [31:0] reqWdata [3];
  logic [1:0]  reqSize  [3];
  logic        reqSigned[3];
  logic [4:0]  reqRd    [3];
  logic        reqRfwr  [3];
  logic [31:0] passData [3];
  logic        stallO   [3];
  logic [31:0] wbData   [3];
  logic [4:0]  wbRd     [3];
  logic        wbRfwr   [3];
  logic        misO     [3];

  int nChk = 0;
  int nErr = 0;
  bit [31:0] mdl [3][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    mem_stage_dmem #(.DEPTH(1024), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u (
      .clk(clk), .rst(rst), .req_valid(reqValid[g]), .req_wr(reqWr[g]),
      .req_addr(reqAddr[g]), .req_wdata(reqWdata[g]), .req_size(reqSize[g]),
      .req_signed(reqSigned[g]), .req_rd(reqRd[g]), .req_rfwr(reqRfwr[g]),
      .pass_data(passData[g]), .stall_o(stallO[g]), .wb_data(wbData[g]),
      .wb_rd(wbRd[g]), .wb_rfwr(wbRfwr[g]), .misalign_o(misO[g]));
  end

  typedef struct {
    bit        wr;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [1:0]  size;
    bit        sgn;
    bit [4:0]  rd;
    bit        rfwr;
    bit [31:0] expData;
    bit        expRfwr;
    bit        expMis;
  } vec_t;

  function automatic int waitOf(input int d);
    return d == 0 ? 0 : (d == 1 ? 2 : 3);
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s dut%0d: got %h want %h", nm, d, act, exp);
    end
  endtask

  function automatic vec_t V(input bit wr, input bit [31:0] a, input bit [31:0] wd, input bit [1:0] sz,
                             input bit sg, input bit rf, input bit [31:0] ed, input bit er, input bit em);
    vec_t v;
    v = '{wr, a, wd, sz, sg, 5'd0, rf, ed, er, em};
    return v;
  endfunction

  // Reference model: byte-addressed view of a 4 KiB word memory.
  task automatic mkVec(input int d, input bit wr, input bit [31:0] a, input bit [31:0] data,
                       input bit [1:0] size, input bit sgn, input bit [4:0] rd, input bit rf,
                       output vec_t v);
    int unsigned w, sh;
    bit [31:0] word, mask, val;
    bit mis;
    w    = (a / 4) % 1024;
    word = mdl[d][w];
    mis  = (size == 2'd1) ? (a % 2 != 0) : (size == 2'd0) ? 1'b0 : (a % 4 != 0);
    v = '{wr, a, data, size, sgn, rd, rf, 32'd0, 1'b0, mis};
    if (mis) return;
    if (wr) begin
      if (size == 2'd0) begin
        sh = 8 * (a % 4); mask = 32'hFF << sh;
        mdl[d][w] = (word & ~mask) | ((data % 256) << sh);
      end else if (size == 2'd1) begin
        sh = 16 * ((a / 2) % 2); mask = 32'hFFFF << sh;
        mdl[d][w] = (word & ~mask) | ((data % 65536) << sh);
      end else begin
        mdl[d][w] = data;
      end
    end else begin
      if (size == 2'd0) begin
        val = (word >> (8 * (a % 4))) % 256;
        if (sgn && val >= 128) val = val + 32'hFFFFFF00;
      end else if (size == 2'd1) begin
        val = (word >> (16 * ((a / 2) % 2))) % 65536;
        if (sgn && val >= 32768) val = val + 32'hFFFF0000;
      end else begin
        val = word;
      end
      v.expData = val;
      v.expRfwr = rf;
    end
  endtask

  task automatic drive(input int d, input vec_t v);
    reqValid[d] = 1'b1; reqWr[d] = v.wr; reqAddr[d] = v.addr; reqWdata[d] = v.wdata;
    reqSize[d] = v.size; reqSigned[d] = v.sgn; reqRd[d] = v.rd; reqRfwr[d] = v.rfwr;
  endtask

  // Called just after a rising edge; returns just after the completion edge.
  task automatic doAcc(input int d, input vec_t v);
    int stalls;
    bit done, s;
    stalls = 0;
    done   = 1'b0;
    drive(d, v);
    for (int c = 0; c < 40 && !done; c++) begin
      #1 s = stallO[d];
      @(posedge clk); #1;
      if (s) begin
        stalls++;
        chk("bubbleRfwr", d, wbRfwr[d], 0);
      end else done = 1'b1;
    end
    if (!done) chk("timeout", d, 0, 1);
    reqValid[d] = 1'b0;
    chk("stallCycles", d, stalls, waitOf(d));
    if (!v.wr || v.expMis) chk("wbData", d, wbData[d], v.expData);
    chk("wbRd", d, wbRd[d], v.rd);
    chk("wbRfwr", d, wbRfwr[d], v.expRfwr);
    chk("misalign", d, misO[d], v.expMis);
  endtask

  task automatic passCyc(input int d);
    bit [31:0] pd;
    bit [4:0]  rd;
    bit        rf;
    pd = $urandom; rd = 5'($urandom); rf = 1'($urandom);
    reqValid[d] = 1'b0; passData[d] = pd; reqRd[d] = rd; reqRfwr[d] = rf;
    #1 chk("passStall", d, stallO[d], 0);
    @(posedge clk); #1;
    chk("passData", d, wbData[d], pd);
    chk("passRd", d, wbRd[d], rd);
    chk("passRfwr", d, wbRfwr[d], rf);
    chk("passMis", d, misO[d], 0);
  endtask

  task automatic chkZero(input int d, input string nm);
    chk({nm, "Data"}, d, wbData[d], 0);
    chk({nm, "Rd"}, d, wbRd[d], 0);
    chk({nm, "Rfwr"}, d, wbRfwr[d], 0);
    chk({nm, "Mis"}, d, misO[d], 0);
    chk({nm, "Stall"}, d, stallO[d], 0);
  endtask

  vec_t tbl [20];
  vec_t v;

  initial begin
    for (int d = 0; d < 3; d++) begin
      reqValid[d] = 1'b0; reqWr[d] = 1'b0; reqAddr[d] = '0; reqWdata[d] = '0;
      reqSize[d] = '0; reqSigned[d] = 1'b0; reqRd[d] = '0; reqRfwr[d] = 1'b0; passData[d] = '0;
    end
    // A pending request during reset must not raise stall.
    reqValid[1] = 1'b1;
    #12;
    for (int d = 0; d < 3; d++) chkZero(d, "reset");
    reqValid[1] = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    tbl[0]  = V(1, 32'h10,   32'hDEADBEEF, 2'd2, 0, 1, 32'h0,        0, 0);
    tbl[1]  = V(0, 32'h10,   32'h0,        2'd2, 0, 1, 32'hDEADBEEF, 1, 0);
    tbl[2]  = V(1, 32'h20,   32'h11223344, 2'd2, 0, 1, 32'h0,        0, 0);
    tbl[3]  = V(1, 32'h21,   32'hAAAAAA80, 2'd0, 0, 1, 32'h0,        0, 0);
    tbl[4]  = V(0, 32'h21,   32'h0,        2'd0, 1, 1, 32'hFFFFFF80, 1, 0);
    tbl[5]  = V(0, 32'h21,   32'h0,        2'd0, 0, 1, 32'h00000080, 1, 0);
    tbl[6]  = V(0, 32'h20,   32'h0,        2'd2, 0, 1, 32'h11228044, 1, 0);
    tbl[7]  = V(0, 32'h13,   32'h0,        2'd1, 0, 1, 32'h0,        0, 1);
    tbl[8]  = V(0, 32'h10,   32'h0,        2'd2, 0, 1, 32'hDEADBEEF, 1, 0);
    tbl[9]  = V(1, 32'h00,   32'hCAFEF00D, 2'd2, 0, 1, 32'h0,        0, 0);
    tbl[10] = V(1, 32'h02,   32'h55555555, 2'd2, 0, 1, 32'h0,        0, 1);
    tbl[11] = V(0, 32'h00,   32'h0,        2'd2, 0, 1, 32'hCAFEF00D, 1, 0);
    tbl[12] = V(1, 32'h1000, 32'h0BADC0DE, 2'd2, 0, 1, 32'h0,        0, 0);
    tbl[13] = V(0, 32'h0000, 32'h0,        2'd2, 0, 1, 32'h0BADC0DE, 1, 0);
    tbl[14] = V(1, 32'h22,   32'hFFFF8001, 2'd1, 0, 1, 32'h0,        0, 0);
    tbl[15] = V(0, 32'h22,   32'h0,        2'd1, 1, 1, 32'hFFFF8001, 1, 0);
    tbl[16] = V(0, 32'h20,   32'h0,        2'd1, 0, 1, 32'h00008044, 1, 0);
    tbl[17] = V(0, 32'h20,   32'h0,        2'd3, 0, 1, 32'h80018044, 1, 0);
    tbl[18] = V(0, 32'h23,   32'h0,        2'd0, 1, 1, 32'hFFFFFF80, 1, 0);
    tbl[19] = V(0, 32'h20,   32'h0,        2'd2, 0, 0, 32'h80018044, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tbl[i].rd = 5'(i + 1);
      doAcc(0, tbl[i]);
      if (i % 4 == 3) passCyc(0);
    end

    // Reset during a BUSY store aborts it; the word keeps its old contents.
    mkVec(1, 1, 32'h40, 32'h0F0F0F0F, 2'd2, 0, 5'd7, 1, v);
    doAcc(1, v);
    v = V(1, 32'h40, 32'h12345678, 2'd2, 0, 1, 0, 0, 0);
    drive(1, v);
    #1 chk("acceptStall", 1, stallO[1], 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chkZero(1, "midReset");
    reqValid[1] = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    mkVec(1, 0, 32'h40, 32'h0, 2'd2, 0, 5'd9, 1, v);
    doAcc(1, v);

    // Randomized traffic on the 0- and 3-wait instances.
    for (int d = 0; d < 3; d += 2) begin
      for (int i = 0; i < 16; i++) begin
        mkVec(d, 1, 32'h100 + 4 * i, $urandom, 2'd2, 0, 5'($urandom), 1, v);
        doAcc(d, v);
      end
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 4) == 0) passCyc(d);
        else begin
          mkVec(d, 1'($urandom), ($urandom & 32'hFFFFF000) | (32'h100 + $urandom_range(0, 63)),
                $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 5'($urandom), 1'($urandom), v);
          doAcc(d, v);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChk, nErr);
    $finish;
  end
endmodule
